// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event decoder.
package button_event_pkg;

    localparam int unsigned MS_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS1,
        ST_GAP,
        ST_PRESS2,
        ST_LONG_HELD
    } state_e;

    localparam state_e              RST_STATE  = ST_IDLE;
    localparam logic [MS_CNT_W-1:0] MS_CNT_RST = '0;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic logic [MS_CNT_W-1:0] sat_inc(input logic [MS_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle ms_tick every TICK_DIV clocks, restartable via clr.
module ms_tick_gen #(
    parameter int unsigned TICK_DIV = 38000
) (
    input  logic clk,
    input  logic n_reset,
    input  logic clr,
    output logic ms_tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign ms_tick = (cnt_q == CNT_W'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || ms_tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button into short/long/double-click events.
// Auto-repeat while held long is built only when BUTTON_REPEAT_EN is defined.
module button_event_decoder
    import button_event_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 38000,
    parameter int unsigned LONG_MS     = 800,
    parameter int unsigned DBL_MS      = 300,
    parameter int unsigned REP_MS      = 100,
    parameter logic        PRESS_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic n_reset,
    input  logic db_in,
    output logic held,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_pulse
);

    if (LONG_MS < 1 || LONG_MS >= 65535 || DBL_MS < 1 || DBL_MS >= 65535 ||
        REP_MS < 1 || REP_MS >= 65535 || TICK_DIV < 2) begin : g_param_err
        $error("button_event_decoder: parameter out of range");
    end

    localparam logic [MS_CNT_W-1:0] LONG_CNT = MS_CNT_W'(LONG_MS);
    localparam logic [MS_CNT_W-1:0] DBL_CNT  = MS_CNT_W'(DBL_MS);

    state_e              state_q, state_d;
    logic                prs_q, prs_d;
    logic                prs_d1_q, prs_d1_d;
    logic [MS_CNT_W-1:0] ms_cnt_q, ms_cnt_d;
    logic                short_q, short_d;
    logic                long_q, long_d;
    logic                dbl_q, dbl_d;
    logic                press_edge;
    logic                clr;
    logic                ms_tick;

`ifdef BUTTON_REPEAT_EN
    localparam logic [MS_CNT_W-1:0] REP_CNT = MS_CNT_W'(REP_MS);
    logic [MS_CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic                rep_q, rep_d;
`endif

    ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk     (clk),
        .n_reset (n_reset),
        .clr     (clr),
        .ms_tick (ms_tick)
    );

    // Next-state and event decisions; counter updates live in the block below
    // so the tick path never forms a combinational loop through one process.
    always_comb begin
        prs_d      = (db_in == PRESS_LEVEL);
        prs_d1_d   = prs_q;
        press_edge = prs_q && !prs_d1_q;
        state_d    = state_q;
        short_d    = 1'b0;
        long_d     = 1'b0;
        dbl_d      = 1'b0;
`ifdef BUTTON_REPEAT_EN
        rep_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (press_edge) state_d = ST_PRESS1;
            end
            ST_PRESS1: begin
                if (ms_cnt_q >= LONG_CNT) begin
                    long_d  = 1'b1;
                    state_d = ST_LONG_HELD;
                end else if (!prs_q) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (press_edge && ms_cnt_q <= DBL_CNT) begin
                    dbl_d   = 1'b1;
                    state_d = ST_PRESS2;
                end else if (ms_cnt_q >= DBL_CNT) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_PRESS2: begin
                if (!prs_q) state_d = ST_IDLE;
            end
            ST_LONG_HELD: begin
                if (!prs_q) begin
                    state_d = ST_IDLE;
`ifdef BUTTON_REPEAT_EN
                end else if (rep_cnt_q >= REP_CNT) begin
                    rep_d = 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        clr      = (state_d != state_q);
        ms_cnt_d = ms_cnt_q;
        if (clr) begin
            ms_cnt_d = MS_CNT_RST;
        end else if (ms_tick) begin
            ms_cnt_d = sat_inc(ms_cnt_q);
        end
`ifdef BUTTON_REPEAT_EN
        rep_cnt_d = rep_cnt_q;
        if (clr || rep_d) begin
            rep_cnt_d = MS_CNT_RST;
        end else if (ms_tick) begin
            rep_cnt_d = sat_inc(rep_cnt_q);
        end
`endif
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= RST_STATE;
            prs_q     <= 1'b0;
            prs_d1_q  <= 1'b0;
            ms_cnt_q  <= MS_CNT_RST;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            dbl_q     <= 1'b0;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_q <= MS_CNT_RST;
            rep_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            prs_q     <= prs_d;
            prs_d1_q  <= prs_d1_d;
            ms_cnt_q  <= ms_cnt_d;
            short_q   <= short_d;
            long_q    <= long_d;
            dbl_q     <= dbl_d;
`ifdef BUTTON_REPEAT_EN
            rep_cnt_q <= rep_cnt_d;
            rep_q     <= rep_d;
`endif
        end
    end

    assign held         = prs_q;
    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
`ifdef BUTTON_REPEAT_EN
    assign repeat_pulse = rep_q;
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with TICK_DIV=4, LONG_MS=10, DBL_MS=5, REP_MS=3.
module tb_button_event_decoder;

    logic clk = 1'b0;
    logic n_reset;
    logic db_in;
    logic held, short_press, long_press, double_click, repeat_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_short, n_long, n_dbl, n_rep, n_multi;
    int at_short, at_long, at_dbl;
    int rep_at [4];
    int t0, t1, t2, r;

    button_event_decoder #(
        .TICK_DIV    (4),
        .LONG_MS     (10),
        .DBL_MS      (5),
        .REP_MS      (3),
        .PRESS_LEVEL (1'b1)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .db_in        (db_in),
        .held         (held),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .repeat_pulse (repeat_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_obs();
        n_short = 0; n_long = 0; n_dbl = 0; n_rep = 0;
        at_short = -1; at_long = -1; at_dbl = -1;
        for (int i = 0; i < 4; i++) rep_at[i] = -1;
    endtask

    // Advance one clock and log every event pulse seen 1 time unit after the edge.
    task automatic tick();
        int np;
        @(posedge clk);
        #1;
        cyc++;
        np = int'(short_press) + int'(long_press) + int'(double_click) + int'(repeat_pulse);
        if (np > 1) n_multi++;
        if (short_press === 1'b1)  begin n_short++; at_short = cyc; end
        if (long_press === 1'b1)   begin n_long++;  at_long  = cyc; end
        if (double_click === 1'b1) begin n_dbl++;   at_dbl   = cyc; end
        if (repeat_pulse === 1'b1) begin
            if (n_rep < 4) rep_at[n_rep] = cyc;
            n_rep++;
        end
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        n_multi = 0;
        clear_obs();
        n_reset = 1'b0;
        db_in   = 1'b0;
        run(3);
        chk("rst_held",   held,         0);
        chk("rst_short",  short_press,  0);
        chk("rst_long",   long_press,   0);
        chk("rst_dbl",    double_click, 0);
        chk("rst_rep",    repeat_pulse, 0);
        n_reset = 1'b1;
        run(5);

        // Long press: hold 12 ms
        clear_obs();
        db_in = 1'b1; t0 = cyc;
        chk("held_lat0", held, 0);
        run(1);
        chk("held_lat1", held, 1);
        run(47);
        db_in = 1'b0;
        run(40);
        chk("long_cnt",   n_long,  1);
        chk("long_at",    at_long, t0 + 43);
        chk("long_short", n_short, 0);
        chk("long_dbl",   n_dbl,   0);
        chk("long_rep",   n_rep,   0);

        // Short click: 2 ms press then idle
        clear_obs();
        db_in = 1'b1; run(8);
        db_in = 1'b0; t1 = cyc;
        run(40);
        chk("short_cnt",  n_short,  1);
        chk("short_at",   at_short, t1 + 23);
        chk("short_long", n_long,   0);
        chk("short_dbl",  n_dbl,    0);

        // Double click: press 2, release 2, press 2
        clear_obs();
        db_in = 1'b1; run(8);
        db_in = 1'b0; run(8);
        db_in = 1'b1; t2 = cyc; run(8);
        db_in = 1'b0; run(40);
        chk("dbl_cnt",   n_dbl,   1);
        chk("dbl_at",    at_dbl,  t2 + 2);
        chk("dbl_short", n_short, 0);
        chk("dbl_long",  n_long,  0);

        // Hold 20 ms: long press plus auto-repeat when built in
        clear_obs();
        db_in = 1'b1; t0 = cyc;
        run(80);
        db_in = 1'b0;
        run(40);
        chk("hold_long_at", at_long, t0 + 43);
`ifdef BUTTON_REPEAT_EN
        chk("rep_cnt", n_rep,     3);
        chk("rep_at0", rep_at[0], t0 + 56);
        chk("rep_at1", rep_at[1], t0 + 68);
        chk("rep_at2", rep_at[2], t0 + 80);
`else
        chk("rep_cnt", n_rep, 0);
`endif

        // Release lands on the exact LONG_MS tick: long wins
        clear_obs();
        db_in = 1'b1; t0 = cyc;
        run(41);
        db_in = 1'b0;
        run(40);
        chk("edge_long_cnt",   n_long,  1);
        chk("edge_long_at",    at_long, t0 + 43);
        chk("edge_long_short", n_short, 0);

        // Release one cycle before the LONG_MS tick: ends as a short click
        clear_obs();
        db_in = 1'b1; run(40);
        db_in = 1'b0; t1 = cyc;
        run(40);
        chk("pre_long_long",  n_long,   0);
        chk("pre_long_short", at_short, t1 + 23);

        // Second press edge on the exact DBL_MS tick, then a long hold in PRESS2
        clear_obs();
        db_in = 1'b1; run(8);
        db_in = 1'b0; t1 = cyc; run(21);
        db_in = 1'b1; t2 = cyc; run(48);
        db_in = 1'b0; run(40);
        chk("edge_dbl_cnt",   n_dbl,   1);
        chk("edge_dbl_at",    at_dbl,  t2 + 2);
        chk("edge_dbl_short", n_short, 0);
        chk("edge_dbl_long",  n_long,  0);

        // Reset during GAP discards the pending short click
        clear_obs();
        db_in = 1'b1; run(8);
        db_in = 1'b0; run(10);
        n_reset = 1'b0; #1;
        chk("gap_rst_held",  held,        0);
        chk("gap_rst_short", short_press, 0);
        run(2);
        n_reset = 1'b1;
        run(40);
        chk("gap_rst_no_short", n_short, 0);

        // Reset mid-press with button still down at reset release
        clear_obs();
        db_in = 1'b1; run(8);
        chk("mid_held", held, 1);
        n_reset = 1'b0; #1;
        chk("mid_rst_held", held, 0);
        run(2);
        n_reset = 1'b1; r = cyc;
        run(60);
        db_in = 1'b0;
        run(40);
        chk("rel_long_cnt", n_long,  1);
        chk("rel_long_at",  at_long, r + 43);
        chk("rel_short",    n_short, 0);
        chk("rel_dbl",      n_dbl,   0);

        chk("one_pulse_per_cycle", n_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter TICK_DIV, default 38000, meaning clk cycles per 1 ms tick (38 MHz).
REQ-002 SHALL have parameter LONG_MS, default 800, meaning hold time in ms that classifies a press as long.
REQ-003 SHALL have parameter DBL_MS, default 300, meaning the maximum release gap in ms for a double click.
REQ-004 SHALL have parameter REP_MS, default 100, meaning the auto-repeat period in ms.
REQ-005 SHALL have parameter PRESS_LEVEL, default 1, meaning the db_in level that means "pressed".
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic on posedge.
REQ-007 SHALL have port n_reset, input, 1 bit: asynchronous active-low reset.
REQ-008 SHALL have port db_in, input, 1 bit: debounced, clk-synchronous button level from the upstream debouncer.
REQ-009 SHALL have port held, output, 1 bit: registered level, high while the button is pressed.
REQ-010 SHALL have port short_press, output, 1 bit: one-cycle pulse for a single short click.
REQ-011 SHALL have port long_press, output, 1 bit: one-cycle pulse when the hold reaches LONG_MS.
REQ-012 SHALL have port double_click, output, 1 bit: one-cycle pulse for the second press of a double click.
REQ-013 SHALL have port repeat_pulse, output, 1 bit: one-cycle auto-repeat pulse; tied 0 when the feature is compiled out.

Function
REQ-014 SHALL register db_in once into prs_q = (db_in == PRESS_LEVEL); press edge = prs_q rising, release = !prs_q.
REQ-015 SHALL generate a one-cycle ms_tick every TICK_DIV clk cycles; the ms counter clears on every state change.
REQ-016 SHALL implement states IDLE, PRESS1, GAP, PRESS2 and LONG_HELD.
REQ-017 IDLE SHALL go to PRESS1 on a press edge.
REQ-018 PRESS1 SHALL emit long_press and go to LONG_HELD when ms count == LONG_MS; otherwise it SHALL go to GAP on release.
REQ-019 When ms count reaches LONG_MS and release occur in the same cycle, long_press SHALL win and LONG_HELD SHALL exit on the next cycle.
REQ-020 GAP SHALL emit double_click and go to PRESS2 on a press edge while ms count < DBL_MS.
REQ-021 GAP SHALL emit short_press and go to IDLE when ms count == DBL_MS; a press edge in that same cycle SHALL count as a double click.
REQ-022 PRESS2 and LONG_HELD SHALL return to IDLE on release level with no further event; PRESS2 SHALL never produce long_press.
REQ-023 All event pulses SHALL be registered and high exactly one cycle, in the cycle after the deciding edge; at most one event pulse SHALL be high per cycle.
REQ-024 held SHALL equal prs_q, i.e. one cycle of latency from db_in.
REQ-025 The ms counter SHALL be 16 bits and saturating, and SHALL never wrap.
REQ-026 Parameters SHALL satisfy LONG_MS, DBL_MS, REP_MS >= 1 and < 65535, and TICK_DIV >= 2; elaboration SHALL fail otherwise.

Reset
REQ-027 n_reset low SHALL asynchronously force state IDLE and clear prs_q, the counters and all outputs to 0.
REQ-028 Release of n_reset SHALL take effect on the next posedge.
REQ-029 If db_in is pressed at reset release, a press edge SHALL be seen on the first clock and no event SHALL be lost or duplicated.
REQ-030 A reset mid-press SHALL discard the pending classification.

Configuration
REQ-031 Macro BUTTON_REPEAT_EN SHALL control auto-repeat.
REQ-032 When BUTTON_REPEAT_EN is defined, LONG_HELD SHALL pulse repeat_pulse every REP_MS ms, the first pulse REP_MS after long_press, stopping on release.
REQ-033 When BUTTON_REPEAT_EN is undefined, repeat_pulse SHALL be constant 0 and the repeat counter SHALL be absent.

Structure
REQ-034 Package button_event_pkg SHALL hold the state enum, MS_CNT_W = 16 and the reset/idle constants.
REQ-035 A sub-module ms_tick_gen (parameter TICK_DIV; ports clk, n_reset, clr, ms_tick) SHALL generate the tick.
REQ-036 The FSM and the counters SHALL remain in button_event_decoder.

Verification (TICK_DIV=4, LONG_MS=10, DBL_MS=5, REP_MS=3)
REQ-037 Press 12 ticks then release -> one long_press 10 ticks after press; no short_press on release.
REQ-038 Press 2 ticks, release, idle 8 ticks -> one short_press 5 ticks after release; no other pulses.
REQ-039 Press 2, release 2, press 2, release -> double_click on the second press edge; no short_press or long_press.
REQ-040 BUTTON_REPEAT_EN defined, hold 20 ticks -> long_press at 10, repeat_pulse at 13, 16 and 19; undefined -> repeat_pulse stays 0.
REQ-041 Release on the exact LONG_MS tick -> long_press only; release on the exact DBL_MS tick with a press edge -> double_click only.
REQ-042 Assert n_reset during GAP -> all outputs 0 at once and no short_press after reset release.
